gray_fifo_ctrl: RTL and testbench

Control block for a 16-entry buffer addressed by offset-Gray pointers. It sequences one write pointer and one read pointer, each a 4-bit binary count with a registered Gray address. It produces the RAM write strobe, Gray read/write addresses, full/empty/almost-full flags, occupancy, and error pulses. It sits between a producer/consumer pair and a 16x`N` dual-port RAM, in the same clock domain as both.

---
 rtl/gray_fifo_pkg.sv | 19 +
 rtl/gray_fifo_ctrl_gray_ptr.sv | 54 +++++
 rtl/gray_fifo_ctrl.sv | 121 ++++++++++++
 tb/tb_gray_fifo_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_fifo_pkg.sv
// Shared types, sizes and helpers for the offset-Gray FIFO controller.
package gray_fifo_pkg;

   localparam int DEPTH = 16;
   localparam int PTR_W = 4;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W:0]   occ_t;

   function automatic ptr_t gray_of(input ptr_t n);
      return n ^ (n >> 1);
   endfunction

   // Bitwise two-of-three majority.
   function automatic ptr_t maj3(input ptr_t a, input ptr_t b, input ptr_t c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/gray_fifo_ctrl_gray_ptr.sv
// Binary pointer with registered offset-Gray address; TMR=1 keeps three
// independent counter copies and votes both the binary and Gray views.
module gray_ptr
   import gray_fifo_pkg::*;
#(
   parameter int TMR = 0
) (
   input  logic CLK,
   input  logic RST,
   input  logic CE,
   output ptr_t BIN,
   output ptr_t GRAY
);

   localparam int NCP = (TMR != 0) ? 3 : 1;

   logic [NCP-1:0][PTR_W-1:0] bin_q, bin_d, gray_n;
   ptr_t gray_q, gray_d;

   // Each copy owns its increment and Gray LUT so a single upset stays local.
   always_comb begin
      for (int i = 0; i < NCP; i++) begin
         bin_d[i]  = bin_q[i] + {{(PTR_W-1){1'b0}}, CE};
         gray_n[i] = gray_of(bin_d[i]);
      end
   end

   generate
      if (NCP == 3) begin : g_tmr
         always_comb begin
            gray_d = maj3(gray_n[0], gray_n[1], gray_n[2]);
            BIN    = maj3(bin_q[0], bin_q[1], bin_q[2]);
         end
      end else begin : g_single
         always_comb begin
            gray_d = gray_n[0];
            BIN    = bin_q[0];
         end
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (!RST) begin
         bin_q  <= '0;
         gray_q <= '0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
      end
   end

   assign GRAY = gray_q;

endmodule

// File: rtl/gray_fifo_ctrl.sv
// 16-entry FIFO controller with offset-Gray RAM addresses and registered flags.
// Optional GRAY_FIFO_ERRCNT_EN adds a saturating OVF/UNF event counter.
module gray_fifo_ctrl
   import gray_fifo_pkg::*;
#(
   parameter int TMR       = 0,
   parameter int AFULL_THR = 12
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       WE,
   input  logic       RE,
   output logic       RAM_WE,
   output logic [3:0] WADDR,
   output logic [3:0] RADDR,
   output logic       RD_VALID,
   output logic       EMPTY,
   output logic       FULL,
   output logic       AFULL,
   output logic [4:0] COUNT,
   output logic       OVF,
`ifdef GRAY_FIFO_ERRCNT_EN
   input  logic       ERRCLR,
   output logic [7:0] ERRCNT,
`endif
   output logic       UNF
);

   ptr_t wbin, rbin;
   logic wr_ok, rd_ok;
   occ_t occ_cur, count_d;
   logic full_q, full_d, empty_q, empty_d, afull_q, afull_d;
   logic ovf_q, ovf_d, unf_q, unf_d, rd_valid_q, rd_valid_d;
   logic wlap_q, wlap_d, rlap_q, rlap_d;

   gray_ptr #(.TMR(TMR)) u_wptr (
      .CLK (CLK),
      .RST (RST),
      .CE  (wr_ok),
      .BIN (wbin),
      .GRAY(WADDR)
   );

   gray_ptr #(.TMR(TMR)) u_rptr (
      .CLK (CLK),
      .RST (RST),
      .CE  (rd_ok),
      .BIN (rbin),
      .GRAY(RADDR)
   );

   // Lap bits extend the voted pointers to 5 bits so 0 and 16 differ.
   always_comb begin
      wr_ok   = WE & ~full_q & RST;
      rd_ok   = RE & ~empty_q & RST;
      occ_cur = {wlap_q, wbin} - {rlap_q, rbin};

      count_d = occ_cur;
      if (wr_ok && !rd_ok)      count_d = occ_cur + occ_t'(1);
      else if (rd_ok && !wr_ok) count_d = occ_cur - occ_t'(1);

      full_d     = (count_d == occ_t'(DEPTH));
      empty_d    = (count_d == '0);
      afull_d    = (count_d >= occ_t'(AFULL_THR));
      wlap_d     = wlap_q ^ (wr_ok & (wbin == ptr_t'(DEPTH-1)));
      rlap_d     = rlap_q ^ (rd_ok & (rbin == ptr_t'(DEPTH-1)));
      ovf_d      = WE & full_q;
      unf_d      = RE & empty_q;
      rd_valid_d = rd_ok;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         afull_q    <= 1'b0;
         wlap_q     <= 1'b0;
         rlap_q     <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         full_q     <= full_d;
         empty_q    <= empty_d;
         afull_q    <= afull_d;
         wlap_q     <= wlap_d;
         rlap_q     <= rlap_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         rd_valid_q <= rd_valid_d;
      end
   end

`ifdef GRAY_FIFO_ERRCNT_EN
   logic [7:0] errcnt_q, errcnt_d;

   // Clear beats a same-cycle increment; counting stops at 255.
   always_comb begin
      errcnt_d = errcnt_q;
      if (ERRCLR)                                errcnt_d = '0;
      else if ((ovf_q || unf_q) && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
   end

   always_ff @(posedge CLK) begin
      if (!RST) errcnt_q <= '0;
      else      errcnt_q <= errcnt_d;
   end

   assign ERRCNT = errcnt_q;
`endif

   assign RAM_WE   = wr_ok;
   assign RD_VALID = rd_valid_q;
   assign EMPTY    = empty_q;
   assign FULL     = full_q;
   assign AFULL    = afull_q;
   assign COUNT    = occ_cur;
   assign OVF      = ovf_q;
   assign UNF      = unf_q;

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Scoreboard bench for gray_fifo_ctrl: a behavioural model pushes expected
// post-edge outputs per cycle; monitors pop and compare them.
module tb_gray_fifo_ctrl;

   logic       CLK = 1'b0;
   logic       RST, WE, RE, ERRCLR;
   logic       RAM_WE, RD_VALID, EMPTY, FULL, AFULL, OVF, UNF;
   logic [3:0] WADDR, RADDR;
   logic [4:0] COUNT;
   logic [7:0] ERRCNT;

   always #5 CLK = ~CLK;

   gray_fifo_ctrl #(.TMR(1), .AFULL_THR(12)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .WE      (WE),
      .RE      (RE),
      .RAM_WE  (RAM_WE),
      .WADDR   (WADDR),
      .RADDR   (RADDR),
      .RD_VALID(RD_VALID),
      .EMPTY   (EMPTY),
      .FULL    (FULL),
      .AFULL   (AFULL),
      .COUNT   (COUNT),
      .OVF     (OVF),
`ifdef GRAY_FIFO_ERRCNT_EN
      .ERRCLR  (ERRCLR),
      .ERRCNT  (ERRCNT),
`endif
      .UNF     (UNF)
   );

`ifndef GRAY_FIFO_ERRCNT_EN
   initial ERRCNT = '0;
`endif

   typedef struct {
      logic [3:0] waddr, raddr;
      logic [4:0] count;
      logic       empty, full, afull, rdv, ovf, unf;
      logic [7:0] errcnt;
   } exp_t;

   exp_t sb[$];
   logic ram_q[$];
   int   checks = 0, errors = 0;

   logic [3:0] gseq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   int m_count = 0, m_wbin = 0, m_rbin = 0, m_err = 0;
   bit m_ovf = 0, m_unf = 0;

   // One cycle of stimulus: drive, predict, then land 2 units after the edge.
   task automatic step(input bit we, input bit re, input bit rst);
      exp_t e;
      bit   wr, rd;
      WE = we; RE = re; RST = rst;
      wr = rst && we && (m_count != 16);
      rd = rst && re && (m_count != 0);
      ram_q.push_back(wr);
      if (!rst) m_err = 0;
      else if (ERRCLR) m_err = 0;
      else if ((m_ovf || m_unf) && m_err < 255) m_err++;
      if (!rst) begin
         m_count = 0; m_wbin = 0; m_rbin = 0; m_ovf = 0; m_unf = 0;
      end else begin
         m_ovf = we && (m_count == 16);
         m_unf = re && (m_count == 0);
         if (wr) m_wbin = (m_wbin + 1) % 16;
         if (rd) m_rbin = (m_rbin + 1) % 16;
         m_count = m_count + (wr ? 1 : 0) - (rd ? 1 : 0);
      end
      e.waddr  = gseq[m_wbin];
      e.raddr  = gseq[m_rbin];
      e.count  = 5'(m_count);
      e.empty  = (m_count == 0);
      e.full   = (m_count == 16);
      e.afull  = (m_count >= 12);
      e.rdv    = rd;
      e.ovf    = m_ovf;
      e.unf    = m_unf;
      e.errcnt = 8'(m_err);
      sb.push_back(e);
      @(posedge CLK);
      #2;
   endtask

   // Combinational write strobe, sampled mid-cycle.
   always @(negedge CLK) begin
      if (ram_q.size() > 0) begin
         logic w;
         w = ram_q.pop_front();
         checks++;
         if (RAM_WE !== w) begin
            errors++;
            $display("FAIL ram_we: got %b expected %b at %0t", RAM_WE, w, $time);
         end
      end
   end

   always @(posedge CLK) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (WADDR !== e.waddr || RADDR !== e.raddr || COUNT !== e.count) begin
            errors++;
            $display("FAIL sb_ptr: got waddr=%h raddr=%h count=%0d expected %h %h %0d at %0t",
                     WADDR, RADDR, COUNT, e.waddr, e.raddr, e.count, $time);
         end
         checks++;
         if (EMPTY !== e.empty || FULL !== e.full || AFULL !== e.afull) begin
            errors++;
            $display("FAIL sb_flags: got e/f/af=%b%b%b expected %b%b%b at %0t",
                     EMPTY, FULL, AFULL, e.empty, e.full, e.afull, $time);
         end
         checks++;
         if (RD_VALID !== e.rdv || OVF !== e.ovf || UNF !== e.unf) begin
            errors++;
            $display("FAIL sb_pulse: got rdv/ovf/unf=%b%b%b expected %b%b%b at %0t",
                     RD_VALID, OVF, UNF, e.rdv, e.ovf, e.unf, $time);
         end
`ifdef GRAY_FIFO_ERRCNT_EN
         checks++;
         if (ERRCNT !== e.errcnt) begin
            errors++;
            $display("FAIL sb_errcnt: got %0d expected %0d at %0t", ERRCNT, e.errcnt, $time);
         end
`endif
      end
   end

   task automatic test_reset();
      step(0, 0, 0);
      step(1, 1, 0);
      checks++;
      if (EMPTY !== 1'b1 || COUNT !== 5'd0 || WADDR !== 4'h0 || RADDR !== 4'h0) begin
         errors++;
         $display("FAIL reset: got empty=%b count=%0d waddr=%h raddr=%h expected 1 0 0 0",
                  EMPTY, COUNT, WADDR, RADDR);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 1);
         checks++;
         if (WADDR !== gseq[(i + 1) % 16]) begin
            errors++;
            $display("FAIL fill_waddr: write %0d got %h expected %h", i, WADDR, gseq[(i + 1) % 16]);
         end
      end
      checks++;
      if (FULL !== 1'b1 || AFULL !== 1'b1 || EMPTY !== 1'b0 || COUNT !== 5'd16) begin
         errors++;
         $display("FAIL fill_full: got f/af/e=%b%b%b count=%0d expected 110 16",
                  FULL, AFULL, EMPTY, COUNT);
      end
   endtask

   task automatic test_full_rw();
      step(1, 1, 1);
      checks++;
      if (OVF !== 1'b1 || COUNT !== 5'd15 || RADDR !== 4'h1 || WADDR !== 4'h0 || RD_VALID !== 1'b1) begin
         errors++;
         $display("FAIL full_rw: got ovf=%b count=%0d raddr=%h waddr=%h rdv=%b expected 1 15 1 0 1",
                  OVF, COUNT, RADDR, WADDR, RD_VALID);
      end
      step(0, 0, 1);
      checks++;
      if (OVF !== 1'b0 || RD_VALID !== 1'b0) begin
         errors++;
         $display("FAIL full_rw_pulse: got ovf=%b rdv=%b expected 0 0", OVF, RD_VALID);
      end
   endtask

   task automatic test_empty();
      for (int i = 0; i < 15; i++) step(0, 1, 1);
      step(0, 1, 1);
      checks++;
      if (UNF !== 1'b1 || RADDR !== 4'h0 || RD_VALID !== 1'b0 || EMPTY !== 1'b1) begin
         errors++;
         $display("FAIL empty_rd: got unf=%b raddr=%h rdv=%b empty=%b expected 1 0 0 1",
                  UNF, RADDR, RD_VALID, EMPTY);
      end
      step(1, 1, 1);
      checks++;
      if (UNF !== 1'b1 || COUNT !== 5'd1 || WADDR !== 4'h1) begin
         errors++;
         $display("FAIL empty_rw: got unf=%b count=%0d waddr=%h expected 1 1 1", UNF, COUNT, WADDR);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] pw, pr;
      for (int i = 0; i < 4; i++) step(1, 0, 1);
      for (int i = 0; i < 40; i++) begin
         pw = WADDR;
         pr = RADDR;
         step(1, 1, 1);
         checks++;
         if (COUNT !== 5'd5 || $countones(WADDR ^ pw) != 1 || $countones(RADDR ^ pr) != 1) begin
            errors++;
            $display("FAIL b2b: step %0d got count=%0d waddr %h->%h raddr %h->%h expected 5, one-bit steps",
                     i, COUNT, pw, WADDR, pr, RADDR);
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) step(1, 0, 1);
      checks++;
      if (COUNT !== 5'd9) begin
         errors++;
         $display("FAIL mid_count: got %0d expected 9", COUNT);
      end
      step(1, 0, 0);
      checks++;
      if (WADDR !== 4'h0 || RADDR !== 4'h0 || EMPTY !== 1'b1 || COUNT !== 5'd0) begin
         errors++;
         $display("FAIL mid_reset: got waddr=%h raddr=%h empty=%b count=%0d expected 0 0 1 0",
                  WADDR, RADDR, EMPTY, COUNT);
      end
      step(0, 0, 1);
   endtask

`ifdef GRAY_FIFO_ERRCNT_EN
   task automatic test_errcnt();
      for (int i = 0; i < 16; i++) step(1, 0, 1);
      for (int i = 0; i < 300; i++) step(1, 0, 1);
      checks++;
      if (ERRCNT !== 8'd255) begin
         errors++;
         $display("FAIL errcnt_sat: got %0d expected 255", ERRCNT);
      end
      ERRCLR = 1'b1;
      step(1, 0, 1);
      ERRCLR = 1'b0;
      checks++;
      if (ERRCNT !== 8'd0 || OVF !== 1'b1) begin
         errors++;
         $display("FAIL errcnt_clr: got errcnt=%0d ovf=%b expected 0 1", ERRCNT, OVF);
      end
   endtask
`endif

   initial begin
      RST = 1'b0; WE = 1'b0; RE = 1'b0; ERRCLR = 1'b0;
      @(posedge CLK);
      #2;
      test_reset();
      test_fill();
      test_full_rw();
      test_empty();
      test_back_to_back();
      test_reset_mid();
`ifdef GRAY_FIFO_ERRCNT_EN
      test_errcnt();
`endif
      step(0, 0, 1);
      checks++;
      if (sb.size() != 0 || ram_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d/%0d scoreboard entries left, expected 0", sb.size(), ram_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
